// File: rtl/theta_slice_if.sv
// Handshake and data bundle between the theta slice engine, the slice reader
// and the writer stage. The engine owns the slave view; the driving
// environment owns the master view.
interface theta_slice_if #(
  parameter int N = 25
);
  logic         start;
  logic [4:0]   turn_in;
  logic         ld_curr_fr;
  logic         ld_prev_fr;
  logic [6:0]   line_number;
  logic [4:0]   turn;
  logic [N-1:0] pin;
  logic [N-1:0] out_slice;
  logic [6:0]   out_line;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         done;

  modport slave (
    input  start, turn_in, pin, out_ready,
    output ld_curr_fr, ld_prev_fr, line_number, turn,
           out_slice, out_line, out_valid, busy, done
  );

  modport master (
    output start, turn_in, pin, out_ready,
    input  ld_curr_fr, ld_prev_fr, line_number, turn,
           out_slice, out_line, out_valid, busy, done
  );
endinterface

// File: rtl/theta_slice_engine.sv
// Theta slice engine: walks the reader through every slice of one round,
// fetching slice z and slice z-1 (mod SLICES), mixes them with the theta
// column-parity step and hands each result to the writer over valid/ready.
module theta_slice_engine #(
  parameter int N      = 25,
  parameter int SLICES = 64
) (
  input  logic         clk,
  input  logic         rst,
  theta_slice_if.slave bus
);

  localparam int ZW = $clog2(SLICES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LDC,
    S_LDP,
    S_CALC,
    S_OUT,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ZW-1:0]         z_q;
  logic signed [N-1:0]   cur_q;
  logic signed [N-1:0]   out_slice_q;
  logic [6:0]            out_line_q;
  logic                  out_valid_q;
  logic                  busy_q;
  logic [4:0]            turn_q;
  logic [6:0]            line_w;

  // Theta column-parity mix: each bit picks up the parity of the column to its
  // left in this slice and of the column to its right in the previous slice.
  function automatic logic [N-1:0] theta_mix(input logic [N-1:0] cur,
                                             input logic [N-1:0] prv);
    logic [4:0]   c_cur;
    logic [4:0]   c_prv;
    logic [N-1:0] r;
    c_cur = '0;
    c_prv = '0;
    r     = '0;
    for (int x = 0; x < 5; x++) begin
      for (int y = 0; y < 5; y++) begin
        c_cur[x] = c_cur[x] ^ cur[5*y+x];
        c_prv[x] = c_prv[x] ^ prv[5*y+x];
      end
    end
    for (int x = 0; x < 5; x++) begin
      for (int y = 0; y < 5; y++) begin
        r[5*y+x] = cur[5*y+x] ^ c_cur[(x+4)%5] ^ c_prv[(x+1)%5];
      end
    end
    return r;
  endfunction

  assign line_w = {1'b0, z_q} + 7'd1;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; start is only honoured from idle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.start) state_d = S_LDC;
      S_LDC:  state_d = S_LDP;
      S_LDP:  state_d = S_CALC;
      S_CALC: state_d = S_OUT;
      S_OUT: begin
        if (bus.out_ready) begin
          if (z_q == ZW'(SLICES - 1)) state_d = S_DONE;
          else                        state_d = S_LDC;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded strobes: one reader request per fetch state, done in S_DONE
  always_comb begin
    bus.ld_curr_fr  = 1'b0;
    bus.ld_prev_fr  = 1'b0;
    bus.done        = 1'b0;
    bus.line_number = line_w;
    case (state_q)
      S_IDLE: bus.line_number = 7'd0;
      S_LDC:  bus.ld_curr_fr  = 1'b1;
      S_LDP:  bus.ld_prev_fr  = 1'b1;
      S_DONE: bus.done        = 1'b1;
      default: ;
    endcase
  end

  // Round bookkeeping and slice datapath; reset clears everything so no
  // partial result survives an abort
  always_ff @(posedge clk) begin
    if (rst) begin
      z_q         <= '0;
      cur_q       <= '0;
      out_slice_q <= '0;
      out_line_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      turn_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            turn_q <= bus.turn_in;
            z_q    <= '0;
            busy_q <= 1'b1;
          end
        end
        S_LDP:  cur_q <= bus.pin;
        S_CALC: begin
          out_slice_q <= theta_mix(cur_q, bus.pin);
          out_line_q  <= line_w;
          out_valid_q <= 1'b1;
        end
        S_OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (z_q != ZW'(SLICES - 1)) z_q <= z_q + 1'b1;
          end
        end
        S_DONE: busy_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.out_slice = out_slice_q;
  assign bus.out_line  = out_line_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.turn      = turn_q;

endmodule

// File: tb/tb_theta_slice_engine.sv
// Directed bench for theta_slice_engine with a registered slice-reader model.
module tb_theta_slice_engine;
  localparam int N      = 25;
  localparam int SLICES = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  theta_slice_if #(.N(N)) bus ();

  theta_slice_engine #(.N(N), .SLICES(SLICES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [N-1:0] mem [0:SLICES-1];
  logic [N-1:0] got [0:SLICES];

  int n_chk  = 0;
  int n_pass = 0;

  // round statistics
  int busy_cyc, acc_cnt, order_err, done_cnt, done_gap, turn_err, both_err;
  int stall_err, stall_done, timeout, post_busy, post_ld;

  // Reader: returns the requested slice one cycle after the request
  always @(posedge clk) begin
    if (rst)                 bus.pin <= '0;
    else if (bus.ld_curr_fr) bus.pin <= mem[6'(bus.line_number - 7'd1)];
    else if (bus.ld_prev_fr) bus.pin <= mem[6'(bus.line_number - 7'd2)];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic run_round(input logic [4:0] t, input int stall_line, input bit poke);
    int cyc, last_acc, done_at, sp;
    bit exp_ldc, saw_done;
    logic [N-1:0] snap_s;
    logic [6:0]   snap_l;
    busy_cyc = 0; acc_cnt = 0; order_err = 0; done_cnt = 0; turn_err = 0;
    both_err = 0; stall_err = 0; stall_done = 0; timeout = 0;
    last_acc = 0; done_at = -100; sp = 0; exp_ldc = 0; saw_done = 0;
    snap_s = '0; snap_l = '0;
    for (int i = 0; i <= SLICES; i++) got[i] = '1;
    @(negedge clk); bus.start = 1'b1; bus.turn_in = t;
    @(negedge clk); bus.start = 1'b0; bus.turn_in = ~t;
    cyc = 0;
    while (!saw_done && cyc < 2000) begin
      if (bus.busy) busy_cyc++;
      if (bus.busy && bus.turn !== t) turn_err++;
      if (bus.ld_curr_fr && bus.ld_prev_fr) both_err++;
      if (cyc == 20 || cyc == 21) bus.start = (cyc == 20);
      if (exp_ldc) begin
        if (!(bus.ld_curr_fr === 1'b1 && bus.line_number === 7'(stall_line + 1))) stall_err++;
        exp_ldc = 0;
      end
      if (sp > 0) begin
        if (bus.out_valid !== 1'b1 || bus.out_slice !== snap_s || bus.out_line !== snap_l ||
            bus.ld_curr_fr !== 1'b0 || bus.ld_prev_fr !== 1'b0) stall_err++;
        sp++;
        if (sp == 8) begin
          bus.out_ready = 1'b1; sp = 0; exp_ldc = 1; stall_done = 1;
        end
      end else if (bus.out_valid && bus.out_line == 7'(stall_line) && stall_done == 0) begin
        bus.out_ready = 1'b0; sp = 1; snap_s = bus.out_slice; snap_l = bus.out_line;
      end
      if (bus.out_valid && bus.out_ready) begin
        acc_cnt++;
        if (bus.out_line !== 7'(acc_cnt)) order_err++;
        got[bus.out_line] = bus.out_slice;
        last_acc = cyc;
      end
      if (bus.done) begin
        done_cnt++; done_at = cyc; saw_done = 1;
        if (poke) bus.start = 1'b1;
      end
      @(negedge clk); cyc++;
    end
    if (!saw_done) timeout = 1;
    done_gap  = done_at - last_acc;
    post_busy = int'(bus.busy);
    bus.start = 1'b0;
    @(negedge clk);
    post_ld   = int'(bus.ld_curr_fr | bus.ld_prev_fr | bus.busy);
  endtask

  initial begin
    int k, nz;
    bus.start = 1'b0; bus.turn_in = '0; bus.out_ready = 1'b1;
    for (int i = 0; i < SLICES; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_ld", 32'({bus.ld_curr_fr, bus.ld_prev_fr}), 0);
    chk("rst_line_number", 32'(bus.line_number), 0);
    chk("rst_turn", 32'(bus.turn), 0);
    chk("rst_out_slice", 32'(bus.out_slice), 0);
    chk("rst_out_line", 32'(bus.out_line), 0);
    rst = 1'b0;

    // all-zero round, turn 3, start pokes mid-round and in done cycle
    run_round(5'd3, 0, 1'b1);
    chk("zero_timeout", 32'(timeout), 0);
    chk("zero_acc_cnt", 32'(acc_cnt), 64);
    chk("zero_order", 32'(order_err), 0);
    nz = 0;
    for (int i = 1; i <= SLICES; i++) if (got[i] !== '0) nz++;
    chk("zero_nonzero_slices", 32'(nz), 0);
    chk("zero_done_cnt", 32'(done_cnt), 1);
    chk("zero_done_gap", 32'(done_gap), 1);
    chk("zero_busy_cycles", 32'(busy_cyc), 257);
    chk("zero_turn_held", 32'(turn_err), 0);
    chk("zero_ld_both", 32'(both_err), 0);
    chk("poke_busy_after_done", 32'(post_busy), 0);
    chk("poke_still_idle", 32'(post_ld), 0);
    chk("poke_turn_kept", 32'(bus.turn), 3);

    // single bit A[0][0] in slice 0
    mem[0] = 25'h0000001;
    run_round(5'd9, 0, 1'b0);
    chk("bit0_timeout", 32'(timeout), 0);
    chk("bit0_line1", 32'(got[1]), 32'h0210843);
    chk("bit0_line2", 32'(got[2]), 32'h1084210);
    chk("bit0_line64", 32'(got[64]), 0);

    // wrap-around: only slice 63
    mem[0] = '0; mem[63] = 25'h0000001;
    run_round(5'd4, 0, 1'b0);
    chk("wrap_line1", 32'(got[1]), 32'h1084210);
    chk("wrap_line64", 32'(got[64]), 32'h0210843);

    // full slice and an off-origin column bit
    mem[63] = '0; mem[10] = 25'h1FFFFFF; mem[20] = 25'h0000002;
    run_round(5'd17, 0, 1'b0);
    chk("ones_line11", 32'(got[11]), 0);
    chk("ones_line12", 32'(got[12]), 32'h1FFFFFF);
    chk("x1_line21", 32'(got[21]), 32'h0421086);
    chk("x1_line22", 32'(got[22]), 32'h0108421);

    // backpressure on slice 5 (line 6)
    mem[10] = '0; mem[20] = '0; mem[5] = 25'h0000001;
    run_round(5'd1, 6, 1'b0);
    chk("bp_timeout", 32'(timeout), 0);
    chk("bp_stall_seen", 32'(stall_done), 1);
    chk("bp_stable", 32'(stall_err), 0);
    chk("bp_acc_cnt", 32'(acc_cnt), 64);
    chk("bp_line6", 32'(got[6]), 32'h0210843);
    chk("bp_line7", 32'(got[7]), 32'h1084210);
    mem[5] = '0;

    // reset while stalled in S_OUT at slice 10
    @(negedge clk); bus.start = 1'b1; bus.turn_in = 5'd12;
    @(negedge clk); bus.start = 1'b0;
    k = 0;
    while (!(bus.out_valid && bus.out_line == 7'd11) && k < 1000) begin
      @(negedge clk); k++;
    end
    chk("mrst_reach_slice10", 32'(k < 1000), 1);
    bus.out_ready = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("mrst_out_valid", 32'(bus.out_valid), 0);
    chk("mrst_busy", 32'(bus.busy), 0);
    chk("mrst_line_number", 32'(bus.line_number), 0);
    bus.out_ready = 1'b1; bus.start = 1'b1; bus.turn_in = 5'd2;
    @(negedge clk); bus.start = 1'b0;
    chk("mrst_restart_ldc", 32'(bus.ld_curr_fr), 1);
    chk("mrst_restart_line", 32'(bus.line_number), 1);
    chk("mrst_restart_turn", 32'(bus.turn), 2);
    k = 0;
    while (!bus.done && k < 2000) begin
      @(negedge clk); k++;
    end
    chk("mrst_round_done", 32'(k < 2000), 1);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/theta_slice_engine.md
Name: theta_slice_engine

Overview:
Downstream consumer of the column-parity slice reader. It sequences the reader through all 64 slices of the 5x5x64 state for one round. For each slice it:
- fetches the current slice z and the previous slice (z-1 mod 64),
- applies the theta column-parity mix,
- emits the transformed 25-bit slice over a valid/ready handshake to the writer stage.

Parameters:
N, 25, slice width in bits; bit index 5*y+x holds lane A[x][y].
SLICES, 64, slices per round; line_number = z+1, range 1..SLICES.

Ports:
clk  input  1  clock, all state updates on posedge.
rst  input  1  reset, synchronous and active-high.
start  input  1  one-cycle request to process one round; ignored while busy.
turn_in  input  5  round index, sampled on accepted start.
ld_curr_fr  output  1  reader request: load slice line_number.
ld_prev_fr  output  1  reader request: load the slice preceding line_number.
line_number  output  7  current slice line, z+1.
turn  output  5  latched round index, driven to the reader.
pin  input  N  reader data; valid the cycle after a ld_* request.
out_slice  output  N  theta-transformed slice.
out_line  output  7  line number of out_slice.
out_valid  output  1  out_slice/out_line valid.
out_ready  input  1  downstream accepts when high together with out_valid.
busy  output  1  high from accepted start until done.
done  output  1  one-cycle pulse after the last slice is accepted.

Behaviour:
Reset (synchronous, rst high at posedge): the following clear to 0 and the FSM enters S_IDLE:
- state
- ld_curr_fr, ld_prev_fr, out_valid, busy, done
- out_slice, out_line, line_number, turn
- internal cur_reg, z

rst overrides every other input, including mid-round; no partial output is completed.

FSM states:
- S_IDLE: busy=0. On start: latch turn<=turn_in, z<=0, busy<=1, go to S_LDC.
- S_LDC: ld_curr_fr=1, line_number=z+1. Go to S_LDP.
- S_LDP: ld_prev_fr=1, same line_number; cur_reg<=pin. Go to S_CALC.
- S_CALC: pin holds the previous slice. Register out_slice<=theta(cur_reg, pin), out_line<=z+1, out_valid<=1. Go to S_OUT.
- S_OUT: hold out_slice/out_line/out_valid stable while out_ready=0. On out_ready=1: out_valid<=0.
  - If z==SLICES-1: go to S_DONE.
  - Else: z<=z+1, go to S_LDC.
- S_DONE: done=1 for one cycle, busy<=0. Go to S_IDLE.

Output decoding and timing:
- ld_curr_fr and ld_prev_fr are decoded from state, so each is high exactly one cycle per slice and never both together.
- Minimum 4 cycles per slice; 256 cycles per round plus S_DONE, with out_ready tied high.

Theta, all indices mod 5:
- C_curr[x] = XOR over y of cur_reg[5y+x].
- C_prev[x] = XOR over y of pin[5y+x].
- out[5y+x] = cur_reg[5y+x] ^ C_curr[x-1] ^ C_prev[x+1].

Boundary conditions:
- Wrap-around: z=0 still issues ld_prev_fr with line_number=1; the reader returns slice 63.
- start during busy: ignored, with no re-latch of turn.
- start in the same cycle as done: ignored; a new start is accepted only in S_IDLE.
- out_ready high outside S_OUT: no effect.
- z is 6 bits; line_number = {1'b0,z}+1, never 0 and never above 64.

Test Plan:
1. Reset mid-round: rst at slice 10 while in S_OUT -> next cycle out_valid=0, busy=0, state S_IDLE; a following start restarts at line_number=1.
2. All-zero state: pin always 0, out_ready=1 -> 64 out_valid pulses, each out_slice=0, with out_line 1..64 in order. done pulses exactly once, 1 cycle after the 64th acceptance. busy is high for 257 cycles.
3. Single bit A[0][0] in slice 0: reader returns 25'h0000001 for line 1, 0 otherwise. Required results:
   - out_line 1 = 25'h0210843.
   - out_line 2 = 25'h1084210 (prev parity C[0] into column 4).
   - out_line 64 = 0.
4. Wrap-around: only slice 63 nonzero, = 25'h0000001 -> out_line 1 = 25'h1084210 (slice 63 used as prev) and out_line 64 = 25'h0210843.
5. Backpressure: out_ready=0 for 7 cycles at slice 5 -> out_valid, out_slice and out_line are stable for all 7 cycles. No ld_curr_fr/ld_prev_fr during the stall. Slice 6 request starts the cycle after out_ready=1.
6. Handshake corner: start pulsed while busy and in the done cycle -> ignored and turn unchanged. start with turn_in=5'd3 in S_IDLE -> turn=3 held for the whole round.
